// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the write-back slice.
//   XLEN / GPR_W  : datapath width and GPR index width
//   RESET_PC      : PC reported on the trace port while in reset or when tracing is off
//   wb_payload_t  : MEM/WB register contents seen by the write-back stage
//   gpr_writable  : true when a destination index names a real (non-r0) register
package pipe_pkg;

    localparam int          XLEN     = 32;
    localparam int          GPR_W    = 5;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  alu_result;
        logic             res_from_mem;
        logic             gr_we;
        logic [GPR_W-1:0] dest;
    } wb_payload_t;

    function automatic logic gpr_writable(input logic [GPR_W-1:0] dest);
        return (dest != {GPR_W{1'b0}});
    endfunction

endpackage

// File: rtl/wb_rdata_hold.sv
// Holds data-SRAM read data across commit stalls. The SRAM output is valid only in the
// first cycle an instruction sits in WB, so it is captured on that cycle if the
// instruction does not commit immediately, and replayed until commit.
// Ports:
//   clk, resetn      clock, async active-low reset
//   in_valid         WB holds a valid instruction
//   commit           instruction commits this cycle
//   data_sram_rdata  raw SRAM read data
//   rdata_eff        read data to use for write-back this cycle
module wb_rdata_hold
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    input  logic            commit,
    input  logic [XLEN-1:0] data_sram_rdata,
    output logic [XLEN-1:0] rdata_eff
);

    logic            held_r;
    logic [XLEN-1:0] rdata_r;

    // Capture SRAM data on the first stalled cycle; release on commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_r  <= 1'b0;
            rdata_r <= {XLEN{1'b0}};
        end else if (commit) begin
            held_r  <= 1'b0;
        end else if (in_valid && !held_r) begin
            held_r  <= 1'b1;
            rdata_r <= data_sram_rdata;
        end else begin
            held_r  <= held_r;
            rdata_r <= rdata_r;
        end
    end

    // Replay the captured word while held; otherwise pass the live SRAM output.
    always_comb begin
        rdata_eff = data_sram_rdata;
        if (held_r) begin
            rdata_eff = rdata_r;
        end else begin
            rdata_eff = data_sram_rdata;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: last pipeline stage. Selects load data or ALU result, drives the
// register-file write port and the bypass/hazard information for ID, and commits with
// zero latency whenever the commit sink is ready.
// Optional feature macro: WB_TRACE_EN (difftest trace port + retired-instruction counter).
// Ports:
//   clk, resetn                       clock, async active-low reset
//   in_valid / in_ready               MEM/WB handshake (in_ready = resetn & commit_ready)
//   commit_ready                      sink back-pressure
//   pc, alu_result, res_from_mem,
//   gr_we, dest                       MEM/WB payload
//   data_sram_rdata                   SRAM read data, valid first cycle only
//   rf_we, rf_waddr, rf_wdata         register-file write port (r0 writes suppressed)
//   wb_byp_valid/dest/data            bypass info for ID
//   debug_wb_pc/rf_we/rf_wnum/rf_wdata trace port
//   retired_cnt                       committed-instruction count
module wb_stage
    import pipe_pkg::*;
#(
    parameter int          RET_CNT_W = 32,
    parameter logic [31:0] RESET_PC  = pipe_pkg::RESET_PC
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 commit_ready,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      alu_result,
    input  logic                 res_from_mem,
    input  logic                 gr_we,
    input  logic [GPR_W-1:0]     dest,
    input  logic [XLEN-1:0]      data_sram_rdata,
    output logic                 rf_we,
    output logic [GPR_W-1:0]     rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 wb_byp_valid,
    output logic [GPR_W-1:0]     wb_byp_dest,
    output logic [XLEN-1:0]      wb_byp_data,
    output logic [XLEN-1:0]      debug_wb_pc,
    output logic [3:0]           debug_wb_rf_we,
    output logic [GPR_W-1:0]     debug_wb_rf_wnum,
    output logic [XLEN-1:0]      debug_wb_rf_wdata,
    output logic [RET_CNT_W-1:0] retired_cnt
);

    wb_payload_t     pl_s;
    logic            ready_s;
    logic            commit_s;
    logic [XLEN-1:0] rdata_eff_s;

    assign pl_s     = {pc, alu_result, res_from_mem, gr_we, dest};
    assign ready_s  = resetn & commit_ready;
    assign commit_s = in_valid & ready_s;
    assign in_ready = ready_s;

    wb_rdata_hold u_hold (
        .clk             (clk),
        .resetn          (resetn),
        .in_valid        (in_valid),
        .commit          (commit_s),
        .data_sram_rdata (data_sram_rdata),
        .rdata_eff       (rdata_eff_s)
    );

    // Write-port and bypass outputs; everything is forced quiet while in reset.
    always_comb begin
        rf_we        = 1'b0;
        rf_waddr     = {GPR_W{1'b0}};
        rf_wdata     = {XLEN{1'b0}};
        wb_byp_valid = 1'b0;
        wb_byp_dest  = {GPR_W{1'b0}};
        wb_byp_data  = {XLEN{1'b0}};
        if (resetn) begin
            rf_we        = commit_s & pl_s.gr_we & gpr_writable(pl_s.dest);
            rf_waddr     = pl_s.dest;
            rf_wdata     = pl_s.res_from_mem ? rdata_eff_s : pl_s.alu_result;
            // Bypass is announced as soon as the instruction is present, stalled or not.
            wb_byp_valid = in_valid & pl_s.gr_we & gpr_writable(pl_s.dest);
            wb_byp_dest  = pl_s.dest;
            wb_byp_data  = rf_wdata;
        end else begin
            rf_we        = 1'b0;
        end
    end

`ifdef WB_TRACE_EN
    logic [RET_CNT_W-1:0] ret_cnt_r;

    // Count every commit, including non-writing instructions; wraps naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ret_cnt_r <= {RET_CNT_W{1'b0}};
        end else if (commit_s) begin
            ret_cnt_r <= ret_cnt_r + RET_CNT_W'(1);
        end else begin
            ret_cnt_r <= ret_cnt_r;
        end
    end

    // Trace port mirrors the commit; PC falls back to RESET_PC while in reset.
    always_comb begin
        debug_wb_pc       = RESET_PC;
        debug_wb_rf_wnum  = {GPR_W{1'b0}};
        if (resetn) begin
            debug_wb_pc      = pl_s.pc;
            debug_wb_rf_wnum = pl_s.dest;
        end else begin
            debug_wb_pc      = RESET_PC;
        end
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wdata = rf_wdata;
    end

    assign retired_cnt = ret_cnt_r;
`else
    // PC is only consumed by the trace port; keep it visibly sunk when tracing is off.
    logic unused_pc_s;
    assign unused_pc_s = ^pl_s.pc;

    assign debug_wb_pc       = RESET_PC;
    assign debug_wb_rf_we    = 4'b0000;
    assign debug_wb_rf_wnum  = {GPR_W{1'b0}};
    assign debug_wb_rf_wdata = {XLEN{1'b0}};
    assign retired_cnt       = {RET_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed, scoreboard-based bench for wb_stage (RET_CNT_W = 4 to exercise wrap).
module tb_wb_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        commit_ready;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] data_sram_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_byp_valid;
    logic [4:0]  wb_byp_dest;
    logic [31:0] wb_byp_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [3:0]  retired_cnt;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb_q[$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [3:0]  exp_ret   = 4'd0;
    logic [31:0] pc_ctr    = 32'h1c00_0100;

    always #5 clk = ~clk;

    wb_stage #(.RET_CNT_W(4)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .commit_ready      (commit_ready),
        .pc                (pc),
        .alu_result        (alu_result),
        .res_from_mem      (res_from_mem),
        .gr_we             (gr_we),
        .dest              (dest),
        .data_sram_rdata   (data_sram_rdata),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .wb_byp_valid      (wb_byp_valid),
        .wb_byp_dest       (wb_byp_dest),
        .wb_byp_data       (wb_byp_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retired_cnt       (retired_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_ret_out();
`ifdef WB_TRACE_EN
        return {28'd0, exp_ret};
`else
        return 32'd0;
`endif
    endfunction

    task automatic rst_checks(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        check({tag, "_byp_valid"}, {31'd0, wb_byp_valid}, 32'd0);
        check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
        check({tag, "_dbg_pc"}, debug_wb_pc, RST_PC);
        check({tag, "_dbg_we"}, {28'd0, debug_wb_rf_we}, 32'd0);
        check({tag, "_retired"}, {28'd0, retired_cnt}, 32'd0);
    endtask

    // One WB cycle: drive at posedge+1, compare at negedge, advance to next posedge+1.
    task automatic cyc(input string tag, input logic v, input logic r,
                       input logic [31:0] alu, input logic rfm, input logic gwe,
                       input logic [4:0] d, input logic [31:0] rd,
                       input logic [31:0] exp_wdata);
        logic exp_byp;
        exp_t e;
        in_valid        = v;
        commit_ready    = r;
        pc              = pc_ctr;
        alu_result      = alu;
        res_from_mem    = rfm;
        gr_we           = gwe;
        dest            = d;
        data_sram_rdata = rd;
        exp_byp = v & gwe & (d != 5'd0);
        if (v && r) begin
            sb_q.push_back('{we: exp_byp, waddr: d, wdata: exp_wdata});
        end
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, r});
        check({tag, "_byp_valid"}, {31'd0, wb_byp_valid}, {31'd0, exp_byp});
        check({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, d});
        check({tag, "_wdata"}, rf_wdata, exp_wdata);
        check({tag, "_byp_data"}, wb_byp_data, exp_wdata);
        check({tag, "_retired"}, {28'd0, retired_cnt}, exp_ret_out());
        if (v && r) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({tag, "_rf_we"}, {31'd0, rf_we}, {31'd0, e.we});
                check({tag, "_commit_addr"}, {27'd0, rf_waddr}, {27'd0, e.waddr});
                check({tag, "_commit_data"}, rf_wdata, e.wdata);
            end
        end else begin
            check({tag, "_rf_we_stall"}, {31'd0, rf_we}, 32'd0);
        end
`ifdef WB_TRACE_EN
        check({tag, "_dbg_pc"}, debug_wb_pc, pc_ctr);
        check({tag, "_dbg_we"}, {28'd0, debug_wb_rf_we}, {28'd0, {4{v & r & exp_byp}}});
        check({tag, "_dbg_wnum"}, {27'd0, debug_wb_rf_wnum}, {27'd0, d});
        check({tag, "_dbg_wdata"}, debug_wb_rf_wdata, exp_wdata);
`else
        check({tag, "_dbg_pc"}, debug_wb_pc, RST_PC);
        check({tag, "_dbg_we"}, {28'd0, debug_wb_rf_we}, 32'd0);
`endif
        @(posedge clk);
        #1;
        if (v && r) begin
            exp_ret = exp_ret + 4'd1;
            pc_ctr  = pc_ctr + 32'd4;
        end
    endtask

    initial begin
        // Reset with a would-be commit presented: all outputs must be gated off.
        resetn = 1'b0; in_valid = 1'b1; commit_ready = 1'b1; pc = 32'h0000_0040;
        alu_result = 32'h0000_AAAA; res_from_mem = 1'b0; gr_we = 1'b1; dest = 5'd7;
        data_sram_rdata = 32'h0;
        #2;
        rst_checks("init");
        @(posedge clk); #1;
        resetn = 1'b1;

        // ALU write-back.
        cyc("alu", 1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b1, 5'd5, 32'hFFFF_0000, 32'h0000_1234);

        // Load stalled for 3 cycles while the SRAM output moves on.
        cyc("ld_s0", 1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 5'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        cyc("ld_s1", 1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 5'd6, 32'h0000_0000, 32'hDEAD_BEEF);
        cyc("ld_s2", 1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 5'd6, 32'h0000_0000, 32'hDEAD_BEEF);
        cyc("ld_c3", 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 5'd6, 32'h0000_0000, 32'hDEAD_BEEF);

        // Write to r0 is suppressed but still retires.
        cyc("r0", 1'b1, 1'b1, 32'h0000_5555, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0000_5555);

        // Four back-to-back loads, each with its own SRAM word.
        cyc("b2b0", 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 5'd1, 32'h1111_0001, 32'h1111_0001);
        cyc("b2b1", 1'b1, 1'b1, 32'h0000_0204, 1'b1, 1'b1, 5'd2, 32'h2222_0002, 32'h2222_0002);
        cyc("b2b2", 1'b1, 1'b1, 32'h0000_0208, 1'b1, 1'b1, 5'd3, 32'h3333_0003, 32'h3333_0003);
        cyc("b2b3", 1'b1, 1'b1, 32'h0000_020C, 1'b1, 1'b1, 5'd4, 32'h4444_0004, 32'h4444_0004);

        // Stalled ALU op: held path must not leak into the ALU result.
        cyc("alu_s0", 1'b1, 1'b0, 32'hCAFE_0001, 1'b0, 1'b1, 5'd8, 32'h9999_9999, 32'hCAFE_0001);
        cyc("alu_c1", 1'b1, 1'b1, 32'hCAFE_0001, 1'b0, 1'b1, 5'd8, 32'h8888_8888, 32'hCAFE_0001);

        // Non-writing instruction and an idle cycle.
        cyc("nowe", 1'b1, 1'b1, 32'h0000_7777, 1'b0, 1'b0, 5'd9, 32'h0, 32'h0000_7777);
        cyc("idle", 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 5'd9, 32'h0, 32'h0000_0001);

        // Reset mid-stall with the hold register loaded.
        cyc("rs_s0", 1'b1, 1'b0, 32'h0000_1111, 1'b1, 1'b1, 5'd9, 32'h55AA_55AA, 32'h55AA_55AA);
        cyc("rs_s1", 1'b1, 1'b0, 32'h0000_1111, 1'b1, 1'b1, 5'd9, 32'h0BAD_0BAD, 32'h55AA_55AA);
        resetn = 1'b0;
        #1;
        rst_checks("midrst");
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_ret = 4'd0;
        sb_q.delete();

        // Hold register was cleared: the fresh SRAM word must be used.
        cyc("post_rst", 1'b1, 1'b1, 32'h0000_1111, 1'b1, 1'b1, 5'd9, 32'h0000_0077, 32'h0000_0077);

        // 16 more commits: 17 since reset, so a 4-bit counter reads 1.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            a = 32'h0001_0000 + 32'(i);
            cyc("wrap", 1'b1, 1'b1, a, 1'b0, i[0], 5'(i + 1), $urandom, a);
        end
        in_valid = 1'b0;
        @(negedge clk);
`ifdef WB_TRACE_EN
        check("wrap_final", {28'd0, retired_cnt}, 32'd1);
`else
        check("wrap_final", {28'd0, retired_cnt}, 32'd0);
`endif
        check("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
